dist_top: RTL and testbench
===========================

DIST_TOP -- requirements
Module: dist_top

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, per-output buffer depth in words; SHALL be a power of 2 and at least 2.
REQ-002 Parameter WIDTH, default 64, data word width in bits.
REQ-003 CLK  input  1  single clock; all state SHALL be on its rising edge.
REQ-004 ASynReset_N  input  1  reset, asynchronous and active-low.
REQ-005 i_DataValid_D  input  1  upstream word valid.
REQ-006 i_DataIn_D  input  WIDTH  upstream word.
REQ-007 i_DestSel_D  input  2  destination of the upstream word: 0=A, 1=B, 2=C, 3=invalid.
REQ-008 o_DataGrant_D  output  1  upstream ready.
REQ-009 o_DataValid_A/B/C  output  1 each  output word valid, one per channel.
REQ-010 o_DataOut_A/B/C  output  WIDTH each  output word, one per channel.
REQ-011 i_DataGrant_A/B/C  input  1 each  downstream ready, one per channel.
REQ-012 o_DestErr  output  1  sticky flag: a word with an invalid destination was dropped.

Function
REQ-013 The block SHALL generate an internal reset with asynchronous assertion and release synchronised through 2 flops on CLK; all state SHALL use this internal reset.
REQ-014 The block SHALL hold one FIFO per channel: FIFO_DEPTH words, read/write pointers wrapping modulo FIFO_DEPTH, and an occupancy counter ranging 0..FIFO_DEPTH.
REQ-015 An upstream transfer SHALL occur in a cycle where i_DataValid_D=1 and o_DataGrant_D=1.
REQ-016 o_DataGrant_D SHALL be combinational: !full of the FIFO selected by i_DestSel_D, and 1 when i_DestSel_D=3.
REQ-017 "full" SHALL be taken from the registered occupancy only; there is no full-bypass.
  - A full FIFO SHALL NOT accept a push in the same cycle it pops.
REQ-018 A transfer with destination 0/1/2 SHALL write i_DataIn_D to that FIFO.
REQ-019 A transfer with destination 3 SHALL discard the word and set o_DestErr the next cycle.
REQ-020 o_DestErr SHALL stay at 1 until reset.
REQ-021 Each o_DataValid_X SHALL equal (occupancy_X != 0), registered.
REQ-022 Each FIFO SHALL be first-word-fall-through: o_DataOut_X presents the head word while o_DataValid_X=1, and all zeros otherwise.
REQ-023 A word pushed at edge N SHALL be visible on its output channel in the cycle after edge N (1-cycle latency).
REQ-024 A downstream pop SHALL occur when o_DataValid_X=1 and i_DataGrant_X=1; the read pointer advances one entry.
REQ-025 i_DataGrant_X while empty SHALL have no effect.
REQ-026 Push and pop on the same FIFO in the same cycle SHALL leave the occupancy unchanged and preserve order.
REQ-027 The three channels SHALL operate independently; backpressure on one channel SHALL NOT block upstream words addressed to another channel.
REQ-028 Word order within each channel SHALL equal upstream acceptance order.
REQ-029 No word SHALL be duplicated, and none lost except destination-3 words.

Reset
REQ-030 While reset is asserted and until it is released synchronously, the block SHALL hold:
  - o_DataValid_A/B/C=0 and o_DataOut_A/B/C=0
  - o_DestErr=0
  - all pointers and occupancy counters at 0
  - o_DataGrant_D=1 (all FIFOs are empty)
REQ-031 Reset asserted mid-operation SHALL discard all buffered words immediately, without waiting for a clock edge.

Verification
REQ-032 Single-word path: reset released, push 0x1111 to dest 0 with i_DataGrant_A=1 -> o_DataValid_A=1 with o_DataOut_A=0x1111 for exactly 1 cycle, starting 1 cycle after acceptance; B and C stay invalid.
REQ-033 Full and backpressure: i_DataGrant_B=0, push 9 words to dest 1 -> the first 8 are accepted and o_DataGrant_D=0 on the 9th; raise i_DataGrant_B -> words 1..8 come out in order, then the 9th is accepted.
REQ-034 Channel independence: A full and stalled, push to dest 2 -> o_DataGrant_D=1 and the word appears on C.
REQ-035 Simultaneous push/pop: occupancy 4 on C, push and pop in the same cycle for 10 cycles -> occupancy stays 4 and output order matches input order.
REQ-036 Invalid destination: push with i_DestSel_D=3 -> the word is accepted and dropped, o_DestErr=1 from the next cycle and stays 1; no output valid rises.
REQ-037 Mid-operation reset: A holds 3 words, assert ASynReset_N low -> all valids=0 immediately; after release, o_DataGrant_D=1 and no stale words appear.

Source files
------------

// File: rtl/dist_top.sv
// dist_top -- one-to-three word distributor with a FWFT buffer per channel.
//
// Upstream words carry a 2-bit destination (0=A, 1=B, 2=C, 3=invalid).
// Each valid destination has its own FIFO, so a stalled channel never
// blocks traffic bound for the others. Words addressed to destination 3
// are accepted and dropped, and they latch a sticky error flag.
//
// Ports
//   CLK                     single clock, rising edge
//   ASynReset_N             async active-low reset, release synchronised
//   i_DataValid_D           upstream word valid
//   i_DataIn_D[WIDTH]       upstream word
//   i_DestSel_D[2]          upstream destination
//   o_DataGrant_D           upstream ready (combinational)
//   o_DataValid_A/B/C       channel word valid
//   o_DataOut_A/B/C[WIDTH]  channel head word, zero while invalid
//   i_DataGrant_A/B/C       channel downstream ready
//   o_DestErr               sticky: a destination-3 word was dropped

// dist_fifo -- first-word-fall-through buffer for one channel.
//
// Ports
//   clk_sys, rst_b          clock and internal (synchronised) reset
//   push, push_data         write request and word; ignored while full
//   pop_rdy                 downstream ready; pops only while valid
//   full                    occupancy == DEPTH, from registered state only
//   valid, data_out         head word and its valid, data zero when empty
module dist_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 64
) (
   input  logic             clk_sys,
   input  logic             rst_b,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop_rdy,
   output logic             full,
   output logic             valid,
   output logic [WIDTH-1:0] data_out
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    occ_q, occ_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic do_push;
   logic do_pop;

   // Full comes from the registered count only: a full FIFO refuses a push
   // even in a cycle where it is also popping.
   assign full    = (occ_q == CW'(DEPTH));
   assign do_push = push & ~full;
   assign do_pop  = valid_q & pop_rdy;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   occ_d = occ_q + CW'(1);
         2'b01:   occ_d = occ_q - CW'(1);
         default: occ_d = occ_q;
      endcase
      // Valid tracks the next occupancy so a word pushed at one edge is
      // presented in the following cycle.
      valid_d = (occ_d != '0);
   end

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         valid_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         valid_q  <= valid_d;
      end
   end

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (do_push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   assign valid    = valid_q;
   assign data_out = valid_q ? mem_q[rd_ptr_q] : '0;

endmodule

module dist_top #(
   parameter int FIFO_DEPTH = 8,
   parameter int WIDTH      = 64
) (
   input  logic             CLK,
   input  logic             ASynReset_N,
   input  logic             i_DataValid_D,
   input  logic [WIDTH-1:0] i_DataIn_D,
   input  logic [1:0]       i_DestSel_D,
   output logic             o_DataGrant_D,
   output logic             o_DataValid_A,
   output logic             o_DataValid_B,
   output logic             o_DataValid_C,
   output logic [WIDTH-1:0] o_DataOut_A,
   output logic [WIDTH-1:0] o_DataOut_B,
   output logic [WIDTH-1:0] o_DataOut_C,
   input  logic             i_DataGrant_A,
   input  logic             i_DataGrant_B,
   input  logic             i_DataGrant_C,
   output logic             o_DestErr
);

   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_chk
      $error("dist_top: FIFO_DEPTH must be a power of 2 and at least 2");
   end

   // Reset asserts asynchronously and releases two clock edges later.
   logic [1:0] rst_sync_q, rst_sync_d;
   logic       rst_b;

   assign rst_sync_d = {rst_sync_q[0], 1'b1};

   always_ff @(posedge CLK or negedge ASynReset_N) begin
      if (!ASynReset_N) begin
         rst_sync_q <= '0;
      end else begin
         rst_sync_q <= rst_sync_d;
      end
   end

   assign rst_b = rst_sync_q[1];

   logic [2:0]       full;
   logic [2:0]       valid;
   logic [2:0]       push_ch;
   logic [2:0]       pop_rdy;
   logic [WIDTH-1:0] data_out [3];
   logic             accept;

   assign pop_rdy = {i_DataGrant_C, i_DataGrant_B, i_DataGrant_A};

   always_comb begin
      case (i_DestSel_D)
         2'd0:    o_DataGrant_D = ~full[0];
         2'd1:    o_DataGrant_D = ~full[1];
         2'd2:    o_DataGrant_D = ~full[2];
         default: o_DataGrant_D = 1'b1;
      endcase
   end

   assign accept = i_DataValid_D & o_DataGrant_D;

   always_comb begin
      push_ch = '0;
      if (accept && (i_DestSel_D != 2'd3)) begin
         push_ch[i_DestSel_D] = 1'b1;
      end
   end

   for (genvar ch = 0; ch < 3; ch++) begin : g_ch
      dist_fifo #(
         .DEPTH (FIFO_DEPTH),
         .WIDTH (WIDTH)
      ) u_fifo (
         .clk_sys   (CLK),
         .rst_b     (rst_b),
         .push      (push_ch[ch]),
         .push_data (i_DataIn_D),
         .pop_rdy   (pop_rdy[ch]),
         .full      (full[ch]),
         .valid     (valid[ch]),
         .data_out  (data_out[ch])
      );
   end

   assign o_DataValid_A = valid[0];
   assign o_DataValid_B = valid[1];
   assign o_DataValid_C = valid[2];
   assign o_DataOut_A   = data_out[0];
   assign o_DataOut_B   = data_out[1];
   assign o_DataOut_C   = data_out[2];

   logic dest_err_q, dest_err_d;

   assign dest_err_d = dest_err_q | (accept & (i_DestSel_D == 2'd3));

   always_ff @(posedge CLK or negedge rst_b) begin
      if (!rst_b) begin
         dest_err_q <= 1'b0;
      end else begin
         dest_err_q <= dest_err_d;
      end
   end

   assign o_DestErr = dest_err_q;

endmodule

// File: tb/tb_dist_top.sv
// Directed bench for dist_top: inputs change and outputs are sampled on the
// falling edge, away from the active rising edge.
module tb_dist_top;

   localparam int W = 64;

   logic         CLK = 1'b0;
   logic         ASynReset_N;
   logic         i_DataValid_D;
   logic [W-1:0] i_DataIn_D;
   logic [1:0]   i_DestSel_D;
   logic         o_DataGrant_D;
   logic         o_DataValid_A, o_DataValid_B, o_DataValid_C;
   logic [W-1:0] o_DataOut_A, o_DataOut_B, o_DataOut_C;
   logic         i_DataGrant_A, i_DataGrant_B, i_DataGrant_C;
   logic         o_DestErr;

   int n_vec = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   dist_top #(.FIFO_DEPTH(8), .WIDTH(W)) dut (
      .CLK           (CLK),
      .ASynReset_N   (ASynReset_N),
      .i_DataValid_D (i_DataValid_D),
      .i_DataIn_D    (i_DataIn_D),
      .i_DestSel_D   (i_DestSel_D),
      .o_DataGrant_D (o_DataGrant_D),
      .o_DataValid_A (o_DataValid_A),
      .o_DataValid_B (o_DataValid_B),
      .o_DataValid_C (o_DataValid_C),
      .o_DataOut_A   (o_DataOut_A),
      .o_DataOut_B   (o_DataOut_B),
      .o_DataOut_C   (o_DataOut_C),
      .i_DataGrant_A (i_DataGrant_A),
      .i_DataGrant_B (i_DataGrant_B),
      .i_DataGrant_C (i_DataGrant_C),
      .o_DestErr     (o_DestErr)
   );

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
      n_vec++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp_v);
      end
   endtask

   task automatic nedge();
      @(negedge CLK);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_va"}, W'(o_DataValid_A), W'(0));
      chk({tag, "_vb"}, W'(o_DataValid_B), W'(0));
      chk({tag, "_vc"}, W'(o_DataValid_C), W'(0));
      chk({tag, "_da"}, o_DataOut_A, W'(0));
      chk({tag, "_db"}, o_DataOut_B, W'(0));
      chk({tag, "_dc"}, o_DataOut_C, W'(0));
   endtask

   // Drives one word for the next rising edge and checks the upstream grant.
   task automatic drive(input logic [1:0] sel, input logic [W-1:0] data, input logic exp_gnt, input string tag);
      i_DataValid_D = 1'b1;
      i_DestSel_D   = sel;
      i_DataIn_D    = data;
      #1;
      chk(tag, W'(o_DataGrant_D), W'(exp_gnt));
   endtask

   task automatic idle_in();
      i_DataValid_D = 1'b0;
      i_DestSel_D   = 2'd0;
      i_DataIn_D    = '0;
   endtask

   initial begin
      ASynReset_N   = 1'b0;
      i_DataGrant_A = 1'b0;
      i_DataGrant_B = 1'b0;
      i_DataGrant_C = 1'b0;
      idle_in();

      // Reset state
      repeat (2) nedge();
      #1;
      chk_idle("rst");
      chk("rst_err", W'(o_DestErr), W'(0));
      chk("rst_gnt", W'(o_DataGrant_D), W'(1));
      nedge();
      ASynReset_N = 1'b1;
      repeat (3) nedge();
      chk_idle("post_rst");

      // Single-word path on A
      i_DataGrant_A = 1'b1;
      drive(2'd0, 64'h1111, 1'b1, "single_gnt");
      nedge();
      idle_in();
      chk("single_va", W'(o_DataValid_A), W'(1));
      chk("single_da", o_DataOut_A, 64'h1111);
      chk("single_vb", W'(o_DataValid_B), W'(0));
      chk("single_vc", W'(o_DataValid_C), W'(0));
      nedge();
      chk_idle("single_end");

      // Full and backpressure on B
      i_DataGrant_B = 1'b0;
      for (int i = 0; i < 8; i++) begin
         drive(2'd1, W'(64'hB0 + i), 1'b1, "fill_b_gnt");
         nedge();
      end
      drive(2'd1, 64'hB8, 1'b0, "full_b_gnt0");
      nedge();
      #1;
      chk("full_b_gnt1", W'(o_DataGrant_D), W'(0));
      i_DataGrant_B = 1'b1;
      // k=0: still full, ninth word refused; k=1: one slot free, accepted
      for (int k = 0; k < 9; k++) begin
         chk("drain_b_v", W'(o_DataValid_B), W'(1));
         chk("drain_b_d", o_DataOut_B, W'(64'hB0 + k));
         if (k == 0) begin
            #1;
            chk("drain_b_gnt_full", W'(o_DataGrant_D), W'(0));
         end else if (k == 1) begin
            #1;
            chk("drain_b_gnt_free", W'(o_DataGrant_D), W'(1));
         end
         nedge();
         if (k == 1) idle_in();
      end
      chk("drain_b_empty", W'(o_DataValid_B), W'(0));
      chk("drain_b_zero", o_DataOut_B, W'(0));

      // Channel independence: A full and stalled, C still accepts
      i_DataGrant_A = 1'b0;
      i_DataGrant_C = 1'b0;
      for (int i = 0; i < 8; i++) begin
         drive(2'd0, W'(64'hA0 + i), 1'b1, "fill_a_gnt");
         nedge();
      end
      drive(2'd0, 64'hAF, 1'b0, "a_full_gnt");
      drive(2'd2, 64'hC0, 1'b1, "c_indep_gnt");
      nedge();
      idle_in();
      chk("c_indep_v", W'(o_DataValid_C), W'(1));
      chk("c_indep_d", o_DataOut_C, 64'hC0);
      i_DataGrant_A = 1'b1;
      i_DataGrant_C = 1'b1;
      for (int k = 0; k < 8; k++) begin
         chk("drain_a_d", o_DataOut_A, W'(64'hA0 + k));
         nedge();
      end
      chk_idle("drain_a_end");

      // Simultaneous push/pop at occupancy 4 on C
      i_DataGrant_C = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(2'd2, W'(64'hC10 + i), 1'b1, "fill_c_gnt");
         nedge();
      end
      i_DataGrant_C = 1'b1;
      for (int k = 0; k < 10; k++) begin
         chk("pp_c_d", o_DataOut_C, W'(64'hC10 + k));
         drive(2'd2, W'(64'hC14 + k), 1'b1, "pp_c_gnt");
         nedge();
      end
      idle_in();
      for (int k = 0; k < 4; k++) begin
         chk("pp_tail_v", W'(o_DataValid_C), W'(1));
         chk("pp_tail_d", o_DataOut_C, W'(64'hC1A + k));
         nedge();
      end
      chk_idle("pp_end");

      // Invalid destination
      chk("err_pre", W'(o_DestErr), W'(0));
      drive(2'd3, 64'hDEAD, 1'b1, "err_gnt");
      nedge();
      idle_in();
      chk("err_set", W'(o_DestErr), W'(1));
      chk_idle("err_drop");
      repeat (3) nedge();
      chk("err_sticky", W'(o_DestErr), W'(1));
      chk_idle("err_late");

      // Mid-operation reset with A holding 3 words
      i_DataGrant_A = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(2'd0, W'(64'hE0 + i), 1'b1, "mr_fill_gnt");
         nedge();
      end
      idle_in();
      chk("mr_pre_v", W'(o_DataValid_A), W'(1));
      chk("mr_pre_d", o_DataOut_A, 64'hE0);
      #2;
      ASynReset_N = 1'b0;
      #1;
      chk_idle("mr_async");
      chk("mr_err", W'(o_DestErr), W'(0));
      chk("mr_gnt", W'(o_DataGrant_D), W'(1));
      repeat (2) nedge();
      ASynReset_N = 1'b1;
      i_DataGrant_A = 1'b1;
      for (int k = 0; k < 4; k++) begin
         nedge();
         chk_idle("mr_after");
         #1;
         chk("mr_after_gnt", W'(o_DataGrant_D), W'(1));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
